// File: rtl/feeder_pkg.sv
// Shared types and default widths for the PE-cluster job feeder.
// Also holds the phase-skipping successor function used by the controller FSM.
package feeder_pkg;

    localparam int DATA_SIZE   = 8;
    localparam int ID_SIZE     = 8;
    localparam int ADDR_WIDTH  = 16;
    localparam int COUNT_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_FLASH  = 3'd2,
        ST_LOAD_W = 3'd3,
        ST_LOAD_A = 3'd4,
        ST_START  = 3'd5,
        ST_WAIT   = 3'd6,
        ST_DONE   = 3'd7
    } feeder_state_t;

    typedef enum logic [1:0] {
        PH_ID   = 2'd0,
        PH_W    = 2'd1,
        PH_A    = 2'd2,
        PH_NONE = 2'd3
    } phase_sel_t;

    // Successor of a state once it completes; empty fetch phases (and FLASH with no IDs) are skipped.
    function automatic feeder_state_t next_after(input feeder_state_t cur,
                                                 input logic id_nz,
                                                 input logic w_nz,
                                                 input logic a_nz);
        feeder_state_t nxt;
        case (cur)
            ST_IDLE:   nxt = id_nz ? ST_SCAN : (w_nz ? ST_LOAD_W : (a_nz ? ST_LOAD_A : ST_START));
            ST_SCAN:   nxt = ST_FLASH;
            ST_FLASH:  nxt = w_nz ? ST_LOAD_W : (a_nz ? ST_LOAD_A : ST_START);
            ST_LOAD_W: nxt = a_nz ? ST_LOAD_A : ST_START;
            ST_LOAD_A: nxt = ST_START;
            ST_START:  nxt = ST_WAIT;
            ST_WAIT:   nxt = ST_DONE;
            ST_DONE:   nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic phase_sel_t phase_of(input feeder_state_t st);
        phase_sel_t ph;
        case (st)
            ST_SCAN:   ph = PH_ID;
            ST_LOAD_W: ph = PH_W;
            ST_LOAD_A: ph = PH_A;
            default:   ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/stream_fetch.sv
// Count/base read-address generator with a one-cycle return tracker.
// Reloaded at the edge that enters each fetch phase; phase_done marks the drain cycle.
module stream_fetch
    import feeder_pkg::*;
#(
    parameter int addrWidth  = ADDR_WIDTH,
    parameter int countWidth = COUNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [addrWidth-1:0]  base,
    input  logic [countWidth-1:0] count,
    output logic                  req,
    output logic [addrWidth-1:0]  addr,
    output logic                  pending,
    output logic                  phase_done
);

    logic [addrWidth-1:0]  addr_r;
    logic [countWidth-1:0] remaining_r;
    logic                  pending_r;
    logic                  req_s;

    assign req_s      = (remaining_r != {countWidth{1'b0}});
    assign req        = req_s;
    assign addr       = addr_r;
    assign pending    = pending_r;
    assign phase_done = pending_r && !req_s;

    // Address/count walk; the address wraps naturally at the register width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r      <= {addrWidth{1'b0}};
            remaining_r <= {countWidth{1'b0}};
            pending_r   <= 1'b0;
        end else begin
            pending_r <= req_s;
            if (load) begin
                addr_r      <= base;
                remaining_r <= count;
            end else if (req_s) begin
                addr_r      <= addr_r + addrWidth'(1);
                remaining_r <= remaining_r - countWidth'(1);
            end
        end
    end

endmodule

// File: rtl/cluster_feeder.sv
// Job controller for one PE cluster: fetches IDs, weights and activations through a
// single read port, flashes the IDs, starts compute and waits for the cluster's done flag.
module cluster_feeder
    import feeder_pkg::*;
#(
    parameter int dataSize  = DATA_SIZE,
    parameter int idSize    = ID_SIZE,
    parameter int addrWidth = ADDR_WIDTH,
    parameter int memWidth  = 2 * idSize
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [COUNT_WIDTH-1:0] cfg_id_count_i,
    input  logic [COUNT_WIDTH-1:0] cfg_wcount_i,
    input  logic [COUNT_WIDTH-1:0] cfg_acount_i,
    input  logic [addrWidth-1:0]   cfg_id_base_i,
    input  logic [addrWidth-1:0]   cfg_w_base_i,
    input  logic [addrWidth-1:0]   cfg_a_base_i,
    output logic                   mem_req_o,
    output logic [addrWidth-1:0]   mem_addr_o,
    input  logic [memWidth-1:0]    mem_rdata_i,
    output logic                   id_scan_en_o,
    output logic [idSize-1:0]      act_id_scan_o,
    output logic [idSize-1:0]      weight_id_scan_o,
    output logic                   mc_controller_id_wren_o,
    output logic                   w_valid_o,
    output logic [dataSize-1:0]    w_data_o,
    output logic                   a_valid_o,
    output logic [dataSize-1:0]    a_data_o,
    output logic                   cluster_enable_o,
    output logic                   start_compute_o,
    input  logic                   flag_done_i,
    output logic                   busy_o,
    output logic                   done_o
);

    feeder_state_t state_r, state_next_s, target_s;
    phase_sel_t    load_phase_s;
    logic          adv_s, load_s;

    logic [COUNT_WIDTH-1:0] id_count_r, w_count_r, a_count_r;
    logic [addrWidth-1:0]   id_base_r, w_base_r, a_base_r;
    logic [COUNT_WIDTH-1:0] eff_id_count_s, eff_w_count_s, eff_a_count_s, load_count_s;
    logic [addrWidth-1:0]   eff_id_base_s, eff_w_base_s, eff_a_base_s, load_base_s;

    logic                 fetch_req_s, pending_s, phase_done_s;
    logic [addrWidth-1:0] fetch_addr_s;

    // In IDLE the live cfg inputs pick the first phase, since they are latched on that same edge.
    assign eff_id_count_s = (state_r == ST_IDLE) ? cfg_id_count_i : id_count_r;
    assign eff_w_count_s  = (state_r == ST_IDLE) ? cfg_wcount_i   : w_count_r;
    assign eff_a_count_s  = (state_r == ST_IDLE) ? cfg_acount_i   : a_count_r;
    assign eff_id_base_s  = (state_r == ST_IDLE) ? cfg_id_base_i  : id_base_r;
    assign eff_w_base_s   = (state_r == ST_IDLE) ? cfg_w_base_i   : w_base_r;
    assign eff_a_base_s   = (state_r == ST_IDLE) ? cfg_a_base_i   : a_base_r;

    // Job configuration capture, only when a job is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_count_r <= {COUNT_WIDTH{1'b0}};
            w_count_r  <= {COUNT_WIDTH{1'b0}};
            a_count_r  <= {COUNT_WIDTH{1'b0}};
            id_base_r  <= {addrWidth{1'b0}};
            w_base_r   <= {addrWidth{1'b0}};
            a_base_r   <= {addrWidth{1'b0}};
        end else if ((state_r == ST_IDLE) && start_i) begin
            id_count_r <= cfg_id_count_i;
            w_count_r  <= cfg_wcount_i;
            a_count_r  <= cfg_acount_i;
            id_base_r  <= cfg_id_base_i;
            w_base_r   <= cfg_w_base_i;
            a_base_r   <= cfg_a_base_i;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Advance condition per state, successor selection and fetch reload for the entered phase.
    always_comb begin
        adv_s        = 1'b0;
        load_base_s  = {addrWidth{1'b0}};
        load_count_s = {COUNT_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE:                      adv_s = start_i;
            ST_SCAN, ST_LOAD_W, ST_LOAD_A: adv_s = phase_done_s;
            ST_FLASH, ST_START, ST_DONE:  adv_s = 1'b1;
            ST_WAIT:                      adv_s = flag_done_i;
            default:                      adv_s = 1'b0;
        endcase
        target_s     = next_after(state_r,
                                  eff_id_count_s != {COUNT_WIDTH{1'b0}},
                                  eff_w_count_s  != {COUNT_WIDTH{1'b0}},
                                  eff_a_count_s  != {COUNT_WIDTH{1'b0}});
        state_next_s = adv_s ? target_s : state_r;
        load_phase_s = phase_of(target_s);
        load_s       = adv_s && (load_phase_s != PH_NONE);
        case (load_phase_s)
            PH_ID: begin
                load_base_s  = eff_id_base_s;
                load_count_s = eff_id_count_s;
            end
            PH_W: begin
                load_base_s  = eff_w_base_s;
                load_count_s = eff_w_count_s;
            end
            PH_A: begin
                load_base_s  = eff_a_base_s;
                load_count_s = eff_a_count_s;
            end
            default: begin
                load_base_s  = {addrWidth{1'b0}};
                load_count_s = {COUNT_WIDTH{1'b0}};
            end
        endcase
    end

    stream_fetch #(
        .addrWidth (addrWidth),
        .countWidth(COUNT_WIDTH)
    ) u_fetch (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .base      (load_base_s),
        .count     (load_count_s),
        .req       (fetch_req_s),
        .addr      (fetch_addr_s),
        .pending   (pending_s),
        .phase_done(phase_done_s)
    );

    assign mem_req_o  = fetch_req_s;
    assign mem_addr_o = fetch_req_s ? fetch_addr_s : {addrWidth{1'b0}};

    // Returned words are steered by the current phase and forced to zero when unqualified.
    assign id_scan_en_o     = pending_s && (state_r == ST_SCAN);
    assign act_id_scan_o    = id_scan_en_o ? mem_rdata_i[2*idSize-1:idSize] : {idSize{1'b0}};
    assign weight_id_scan_o = id_scan_en_o ? mem_rdata_i[idSize-1:0] : {idSize{1'b0}};
    assign w_valid_o        = pending_s && (state_r == ST_LOAD_W);
    assign w_data_o         = w_valid_o ? mem_rdata_i[dataSize-1:0] : {dataSize{1'b0}};
    assign a_valid_o        = pending_s && (state_r == ST_LOAD_A);
    assign a_data_o         = a_valid_o ? mem_rdata_i[dataSize-1:0] : {dataSize{1'b0}};

    assign mc_controller_id_wren_o = (state_r == ST_FLASH);
    assign start_compute_o         = (state_r == ST_START);
    assign done_o                  = (state_r == ST_DONE);
    assign busy_o                  = (state_r != ST_IDLE);
    assign cluster_enable_o        = busy_o;

endmodule

// File: tb/tb_cluster_feeder.sv
// Bench for cluster_feeder: per-cycle trace from a job-level schedule model, table-driven
// directed jobs with hand-computed lengths, reset sequences and randomized jobs.
module tb_cluster_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  cfg_id_count_i, cfg_wcount_i, cfg_acount_i;
    logic [15:0] cfg_id_base_i, cfg_w_base_i, cfg_a_base_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_rdata_i;
    logic        id_scan_en_o;
    logic [7:0]  act_id_scan_o, weight_id_scan_o;
    logic        mc_controller_id_wren_o;
    logic        w_valid_o, a_valid_o;
    logic [7:0]  w_data_o, a_data_o;
    logic        cluster_enable_o, start_compute_o, flag_done_i, busy_o, done_o;

    int checks = 0;
    int failures = 0;
    logic [15:0] key = 16'h0000;

    cluster_feeder dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .cfg_id_count_i(cfg_id_count_i), .cfg_wcount_i(cfg_wcount_i), .cfg_acount_i(cfg_acount_i),
        .cfg_id_base_i(cfg_id_base_i), .cfg_w_base_i(cfg_w_base_i), .cfg_a_base_i(cfg_a_base_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .id_scan_en_o(id_scan_en_o), .act_id_scan_o(act_id_scan_o), .weight_id_scan_o(weight_id_scan_o),
        .mc_controller_id_wren_o(mc_controller_id_wren_o),
        .w_valid_o(w_valid_o), .w_data_o(w_data_o), .a_valid_o(a_valid_o), .a_data_o(a_data_o),
        .cluster_enable_o(cluster_enable_o), .start_compute_o(start_compute_o),
        .flag_done_i(flag_done_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Memory: requested word one cycle later, junk otherwise so unqualified data is exposed.
    always @(posedge clk) mem_rdata_i <= mem_req_o ? (mem_addr_o ^ key) : 16'($urandom);

    typedef struct packed {
        logic        req;
        logic [15:0] addr;
        logic        scan_en;
        logic [7:0]  act_id;
        logic [7:0]  w_id;
        logic        wren;
        logic        wv;
        logic [7:0]  wd;
        logic        av;
        logic [7:0]  ad;
        logic        cen;
        logic        sc;
        logic        busy;
        logic        done;
    } out_t;

    typedef struct {
        logic flag;
        out_t exp;
    } step_t;

    typedef struct {
        int          n, w, a;
        logic [15:0] bi, bw, ba;
        int          delay;
        int          exp_len;
    } vec_t;

    out_t  got;
    step_t trace[$];
    vec_t  vecs[$];

    always_comb got = {mem_req_o, mem_addr_o, id_scan_en_o, act_id_scan_o, weight_id_scan_o,
                       mc_controller_id_wren_o, w_valid_o, w_data_o, a_valid_o, a_data_o,
                       cluster_enable_o, start_compute_o, busy_o, done_o};

    function automatic out_t busy_rec();
        out_t o = '0;
        o.busy = 1'b1;
        o.cen  = 1'b1;
        return o;
    endfunction

    task automatic push(input out_t o, input logic flag);
        step_t s;
        s.flag = flag;
        s.exp  = o;
        trace.push_back(s);
    endtask

    // One fetch phase: request k in cycle k, its data in cycle k+1, c+1 cycles total.
    task automatic add_phase(input int kind, input int c, input logic [15:0] base);
        out_t o;
        logic [15:0] d;
        if (c > 0) begin
            for (int k = 0; k <= c; k++) begin
                o = busy_rec();
                if (k < c) begin
                    o.req  = 1'b1;
                    o.addr = 16'((int'(base) + k) % 65536);
                end
                if (k > 0) begin
                    d = 16'((int'(base) + k - 1) % 65536) ^ key;
                    case (kind)
                        0: begin o.scan_en = 1'b1; o.act_id = d[15:8]; o.w_id = d[7:0]; end
                        1: begin o.wv = 1'b1; o.wd = d[7:0]; end
                        default: begin o.av = 1'b1; o.ad = d[7:0]; end
                    endcase
                end
                push(o, 1'($urandom % 2));
            end
        end
    endtask

    task automatic build_trace(input int n, input int w, input int a, input logic [15:0] bi,
                               input logic [15:0] bw, input logic [15:0] ba, input int delay);
        out_t o;
        trace.delete();
        add_phase(0, n, bi);
        if (n > 0) begin
            o = busy_rec(); o.wren = 1'b1; push(o, 1'($urandom % 2));
        end
        add_phase(1, w, bw);
        add_phase(2, a, ba);
        o = busy_rec(); o.sc = 1'b1; push(o, 1'($urandom % 2));
        for (int j = 0; j <= delay; j++) begin
            o = busy_rec(); push(o, (j == delay));
        end
        o = busy_rec(); o.done = 1'b1; push(o, 1'($urandom % 2));
        o = '0; push(o, 1'($urandom % 2));
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL %s got=%h exp=0", name, got);
        end
    endtask

    // Start a job on the next edge, then compare each following cycle against the trace.
    task automatic run_job(input int n, input int w, input int a, input logic [15:0] bi,
                           input logic [15:0] bw, input logic [15:0] ba, input int delay,
                           input int limit, output int busy_cnt);
        build_trace(n, w, a, bi, bw, ba, delay);
        busy_cnt = 0;
        @(negedge clk);
        cfg_id_count_i = 8'(n); cfg_wcount_i = 8'(w); cfg_acount_i = 8'(a);
        cfg_id_base_i = bi; cfg_w_base_i = bw; cfg_a_base_i = ba;
        start_i = 1'b1;
        flag_done_i = 1'($urandom % 2);
        @(posedge clk);
        for (int i = 0; i < trace.size() && i < limit; i++) begin
            @(negedge clk);
            start_i = trace[i].exp.busy ? 1'($urandom % 2) : 1'b0;
            if (trace[i].exp.busy) begin
                cfg_id_count_i = 8'($urandom); cfg_wcount_i = 8'($urandom); cfg_acount_i = 8'($urandom);
                cfg_id_base_i = 16'($urandom); cfg_w_base_i = 16'($urandom); cfg_a_base_i = 16'($urandom);
            end
            flag_done_i = trace[i].flag;
            #1;
            checks++;
            if (got !== trace[i].exp) begin
                failures++;
                $display("FAIL trace step=%0d got=%h exp=%h", i, got, trace[i].exp);
            end
            if (busy_o) busy_cnt++;
        end
    endtask

    int blen;

    initial begin
        rst = 1'b1; start_i = 1'b0; flag_done_i = 1'b0;
        cfg_id_count_i = 8'd0; cfg_wcount_i = 8'd0; cfg_acount_i = 8'd0;
        cfg_id_base_i = 16'd0; cfg_w_base_i = 16'd0; cfg_a_base_i = 16'd0;

        vecs.push_back('{n:3, w:3, a:10, bi:16'h0000, bw:16'h0010, ba:16'h0020, delay:5, exp_len:28});
        vecs.push_back('{n:0, w:0, a:2,  bi:16'h0100, bw:16'h0200, ba:16'h0300, delay:0, exp_len:6});
        vecs.push_back('{n:0, w:3, a:0,  bi:16'h0000, bw:16'hFFFE, ba:16'h0000, delay:2, exp_len:9});
        vecs.push_back('{n:0, w:0, a:0,  bi:16'h1234, bw:16'h5678, ba:16'h9ABC, delay:0, exp_len:3});
        vecs.push_back('{n:1, w:0, a:0,  bi:16'hBEEF, bw:16'h0000, ba:16'h0000, delay:1, exp_len:7});
        vecs.push_back('{n:2, w:1, a:1,  bi:16'hFFFF, bw:16'h7FFF, ba:16'hFFFF, delay:3, exp_len:14});

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_i = 1'($urandom % 2);
            flag_done_i = 1'($urandom % 2);
            #1 check_zero("reset_hold");
        end
        start_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;

        foreach (vecs[v]) begin
            run_job(vecs[v].n, vecs[v].w, vecs[v].a, vecs[v].bi, vecs[v].bw, vecs[v].ba,
                    vecs[v].delay, 1000, blen);
            checks++;
            if (blen != vecs[v].exp_len) begin
                failures++;
                $display("FAIL job_len vec=%0d got=%0d exp=%0d", v, blen, vecs[v].exp_len);
            end
        end

        // Abort a job in LOAD_A with an asynchronous reset, then run a fresh job.
        key = 16'h3C5A;
        run_job(0, 1, 8, 16'h0040, 16'h0050, 16'h0060, 2, 6, blen);
        rst = 1'b1;
        #1 check_zero("reset_async");
        @(negedge clk);
        start_i = 1'b1;
        #1 check_zero("reset_held_start");
        start_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        run_job(2, 2, 3, 16'h0A00, 16'h0B00, 16'h0C00, 1, 1000, blen);
        checks++;
        if (blen != 3 + 1 + 3 + 4 + 1 + 2 + 1) begin
            failures++;
            $display("FAIL post_reset_len got=%0d exp=%0d", blen, 15);
        end

        for (int r = 0; r < 25; r++) begin
            key = 16'($urandom);
            run_job(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                    16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 6)), 1000, blen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
